// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one FIFO write port among NUM_REQ producers,
// granting bounded bursts and holding off writes while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_req,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                r_state, w_nextState;
  logic [IW-1:0]         r_owner, w_nextOwner;
  logic [IW-1:0]         r_rrPtr, w_nextRrPtr;
  logic [CW-1:0]         r_burstCnt, w_nextBurstCnt;
  logic [CW-1:0]         w_cntInc;
  logic [IW-1:0]         w_pick;
  logic [IW:0]           w_cand;
  logic                  w_found;
  logic                  w_wrEn;
  logic                  w_endGrant;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_slice[gi] = data_req[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_wrEn   = (r_state == GRANT) && req[r_owner] && !full;
  assign wr_en    = w_wrEn;
  assign gnt      = w_wrEn ? (NUM_REQ'(1) << r_owner) : '0;
  assign data_out = w_wrEn ? w_slice[r_owner] : '0;
  assign busy     = (r_state == GRANT);
  assign owner    = r_owner;
  assign w_cntInc = r_burstCnt + CW'(1);

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ (works for non-power-of-2 counts)
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rrPtr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NUM_REQ)) w_cand = w_cand - (IW+1)'(NUM_REQ);
      if (!w_found && req[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextOwner    = r_owner;
    w_nextRrPtr    = r_rrPtr;
    w_nextBurstCnt = r_burstCnt;
    w_endGrant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextOwner    = w_pick;
          w_nextBurstCnt = '0;
          w_nextState    = GRANT;
        end
      end
      GRANT: begin
        // full alone only stalls; the owner keeps the port until it writes or drops req
        if (!req[r_owner]) begin
          w_endGrant = 1'b1;
        end else if (!full) begin
          if (w_cntInc == CW'(MAX_BURST)) w_endGrant = 1'b1;
          else                            w_nextBurstCnt = w_cntInc;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (w_endGrant) begin
      w_nextState    = IDLE;
      w_nextBurstCnt = '0;
      w_nextRrPtr    = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
    end
  end

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rrPtr    <= '0;
      r_burstCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_owner    <= w_nextOwner;
      r_rrPtr    <= w_nextRrPtr;
      r_burstCnt <= w_nextBurstCnt;
    end
  end

endmodule
